// File: rtl/veda_dp_mem_if.sv
// Bus bundle for veda_dp_mem: masked write port, two read ports, clear request and status.
// The master drives requests; the memory (slave) returns read data, valid flags and status.
interface veda_dp_mem_if #(
   parameter int width  = 32,
   parameter int addr_w = 5
);
   logic                  clear_req;
   logic                  wr_en;
   logic [addr_w-1:0]     wr_addr;
   logic [width-1:0]      wr_data;
   logic [width/8-1:0]    wr_mask;
   logic                  rd_en_a;
   logic [addr_w-1:0]     rd_addr_a;
   logic [width-1:0]      rd_data_a;
   logic                  rd_valid_a;
   logic                  rd_en_b;
   logic [addr_w-1:0]     rd_addr_b;
   logic [width-1:0]      rd_data_b;
   logic                  rd_valid_b;
   logic                  busy;
   logic                  addr_err;

   modport master (
      output clear_req, wr_en, wr_addr, wr_data, wr_mask,
      output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy, addr_err
   );

   modport slave (
      input  clear_req, wr_en, wr_addr, wr_data, wr_mask,
      input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy, addr_err
   );
endinterface

// File: rtl/veda_dp_mem.sv
// Data memory with one byte-masked write port, two registered read ports with
// write-first forwarding, range checking and a word-by-word hardware clear sequencer.
module veda_dp_mem #(
   parameter int width  = 32,
   parameter int depth  = 32,
   parameter int addr_w = 5
) (
   input  logic           clk,
   input  logic           reset,
   veda_dp_mem_if.slave   bus
);
   localparam int                nbytes   = width / 8;
   localparam logic [addr_w:0]   depth_x  = (addr_w + 1)'(depth);
   localparam logic [addr_w-1:0] last_ptr = addr_w'(depth - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [addr_w-1:0]   ptr_r;
   logic [addr_w-1:0]   ptr_s;
   logic [width-1:0]    mem_r [depth];

   logic [width-1:0]    rd_data_a_r;
   logic [width-1:0]    rd_data_b_r;
   logic                rd_valid_a_r;
   logic                rd_valid_b_r;
   logic                addr_err_r;
   logic [width-1:0]    rd_data_a_s;
   logic [width-1:0]    rd_data_b_s;
   logic                rd_valid_a_s;
   logic                rd_valid_b_s;
   logic                addr_err_s;

   logic                accept_s;
   logic                wr_ok_s;
   logic                a_ok_s;
   logic                b_ok_s;
   logic [width-1:0]    wr_word_s;
   logic [width-1:0]    rd_word_a_s;
   logic [width-1:0]    rd_word_b_s;

   function automatic logic [width-1:0] merge_bytes(
      input logic [width-1:0]  old_word,
      input logic [width-1:0]  new_word,
      input logic [nbytes-1:0] mask
   );
      logic [width-1:0] res;
      for (int i = 0; i < nbytes; i++) begin
         res[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

   // Compare in addr_w+1 bits so depth == 2**addr_w needs no special case.
   function automatic logic in_range(input logic [addr_w-1:0] addr);
      return ({1'b0, addr} < depth_x);
   endfunction

   // Request qualification, merged write word and forwarded read words.
   always_comb begin
      accept_s    = (state_r == IDLE) && !bus.clear_req;
      wr_ok_s     = bus.wr_en && in_range(bus.wr_addr);
      a_ok_s      = in_range(bus.rd_addr_a);
      b_ok_s      = in_range(bus.rd_addr_b);
      wr_word_s   = merge_bytes(mem_r[bus.wr_addr], bus.wr_data, bus.wr_mask);
      rd_word_a_s = (wr_ok_s && (bus.wr_addr == bus.rd_addr_a)) ? wr_word_s : mem_r[bus.rd_addr_a];
      rd_word_b_s = (wr_ok_s && (bus.wr_addr == bus.rd_addr_b)) ? wr_word_s : mem_r[bus.rd_addr_b];
   end

   // Next-state logic for the IDLE/CLEAR sequencer and its word pointer.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      case (state_r)
         IDLE: begin
            if (bus.clear_req) begin
               state_s = CLEAR;
               ptr_s   = '0;
            end else begin
               state_s = IDLE;
               ptr_s   = ptr_r;
            end
         end
         CLEAR: begin
            if (ptr_r == last_ptr) begin
               state_s = IDLE;
               ptr_s   = '0;
            end else begin
               state_s = CLEAR;
               ptr_s   = ptr_r + 1'b1;
            end
         end
         default: begin
            state_s = CLEAR;
            ptr_s   = '0;
         end
      endcase
   end

   // Next values of the read ports and the range-error pulse.
   always_comb begin
      rd_data_a_s  = rd_data_a_r;
      rd_data_b_s  = rd_data_b_r;
      rd_valid_a_s = 1'b0;
      rd_valid_b_s = 1'b0;
      if (accept_s && bus.rd_en_a) begin
         rd_valid_a_s = 1'b1;
         rd_data_a_s  = a_ok_s ? rd_word_a_s : '0;
      end else begin
         rd_valid_a_s = 1'b0;
      end
      if (accept_s && bus.rd_en_b) begin
         rd_valid_b_s = 1'b1;
         rd_data_b_s  = b_ok_s ? rd_word_b_s : '0;
      end else begin
         rd_valid_b_s = 1'b0;
      end
      addr_err_s = accept_s && ((bus.wr_en && !in_range(bus.wr_addr)) ||
                                (bus.rd_en_a && !a_ok_s) ||
                                (bus.rd_en_b && !b_ok_s));
   end

   // Sequencer state and registered outputs; reset restarts the clear from word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= CLEAR;
         ptr_r        <= '0;
         rd_data_a_r  <= '0;
         rd_data_b_r  <= '0;
         rd_valid_a_r <= 1'b0;
         rd_valid_b_r <= 1'b0;
         addr_err_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         ptr_r        <= ptr_s;
         rd_data_a_r  <= rd_data_a_s;
         rd_data_b_r  <= rd_data_b_s;
         rd_valid_a_r <= rd_valid_a_s;
         rd_valid_b_r <= rd_valid_b_s;
         addr_err_r   <= addr_err_s;
      end
   end

   // Storage array: zeroed one word per cycle while clearing, masked writes otherwise.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_r == CLEAR) begin
            mem_r[ptr_r] <= '0;
         end else if (accept_s && wr_ok_s) begin
            mem_r[bus.wr_addr] <= wr_word_s;
         end
      end
   end

   assign bus.rd_data_a  = rd_data_a_r;
   assign bus.rd_data_b  = rd_data_b_r;
   assign bus.rd_valid_a = rd_valid_a_r;
   assign bus.rd_valid_b = rd_valid_b_r;
   assign bus.addr_err   = addr_err_r;
   assign bus.busy       = (state_r == CLEAR);
endmodule
